// File: rtl/phy_rx_fifo.sv
// Receive elastic buffer between the PHY and the link layer.
// The PHY cannot be stalled, so pushes that arrive while full are dropped and counted.
module phy_rx_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  overflow,
    output logic                  underflow,
    output logic [7:0]            drop_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_V  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] OCC_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] OCC_ONE  = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  pop_ok;
    logic                  push_ok;
    logic                  push_drop;
    logic [ADDR_WIDTH:0]   occ_next;

    // A pop frees a slot in the same edge, so a push into a full FIFO survives when paired with a pop.
    always_comb begin
        pop_ok    = pop && (occupancy != OCC_ZERO);
        push_ok   = valid_in && (!fifo_full || pop_ok);
        push_drop = valid_in && !push_ok;
        occ_next  = occupancy;
        if (push_ok && !pop_ok) begin
            occ_next = occupancy + OCC_ONE;
        end else if (pop_ok && !push_ok) begin
            occ_next = occupancy - OCC_ONE;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            valid_out   <= pop_ok;
            occupancy   <= occ_next;
            fifo_empty  <= (occ_next == OCC_ZERO);
            fifo_full   <= (occ_next == DEPTH_V);
            almost_full <= (occ_next >= AFULL_V);
            if (push_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_fifo.sv
// Directed bench for phy_rx_fifo: ordering, full/empty boundaries, sticky errors, reset recovery.
module tb_phy_rx_fifo;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        pop;
    logic [31:0] data_out;
    logic        valid_out;
    logic        fifo_empty;
    logic        fifo_full;
    logic        almost_full;
    logic [3:0]  occupancy;
    logic        overflow;
    logic        underflow;
    logic [7:0]  drop_count;

    int vectors    = 0;
    int miscompares = 0;

    phy_rx_fifo dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .occupancy   (occupancy),
        .overflow    (overflow),
        .underflow   (underflow),
        .drop_count  (drop_count)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic p);
        valid_in = v;
        data_in  = d;
        pop      = p;
        @(posedge clk_32f);
        #1;
        valid_in = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] occ, input logic emp,
                             input logic ful, input logic af, input logic ovf,
                             input logic unf, input logic [7:0] drops);
        chk({tag, ".occ"},   32'(occupancy),   32'(occ));
        chk({tag, ".empty"}, 32'(fifo_empty),  32'(emp));
        chk({tag, ".full"},  32'(fifo_full),   32'(ful));
        chk({tag, ".afull"}, 32'(almost_full), 32'(af));
        chk({tag, ".ovf"},   32'(overflow),    32'(ovf));
        chk({tag, ".unf"},   32'(underflow),   32'(unf));
        chk({tag, ".drops"}, 32'(drop_count),  32'(drops));
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; pop = 1'b0; data_in = '0;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0);
        chk("rst.data", data_out, 32'h0);
        chk("rst.valid", 32'(valid_out), 32'h0);
        chk_flags("rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Three words in, three out, one cycle after each pop.
        cyc(1'b1, 32'hAAAA0001, 1'b0);
        chk("p3.valid_during_push", 32'(valid_out), 32'h0);
        cyc(1'b1, 32'hAAAA0002, 1'b0);
        cyc(1'b1, 32'hAAAA0003, 1'b0);
        chk("p3.occ", 32'(occupancy), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("p3.valid", 32'(valid_out), 32'h1);
            chk("p3.data", data_out, 32'hAAAA0000 + 32'(i));
        end
        chk_flags("p3.drained", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("p3.valid_off", 32'(valid_out), 32'h0);
        chk("p3.data_hold", data_out, 32'hAAAA0003);

        // Fill to DEPTH, watching almost_full cross at 6.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h100 + 32'(i), 1'b0);
            chk("fill.afull", 32'(almost_full), (i + 1 >= 6) ? 32'h1 : 32'h0);
            chk("fill.full", 32'(fifo_full), (i == 7) ? 32'h1 : 32'h0);
        end
        cyc(1'b1, 32'hDEAD, 1'b0);
        chk_flags("ovf1", 4'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 255; i++) cyc(1'b1, 32'hDEAD, 1'b0);
        chk("ovf.saturate", 32'(drop_count), 32'd255);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("ovf.valid", 32'(valid_out), 32'h1);
            chk("ovf.data", data_out, 32'h100 + 32'(i));
        end
        chk_flags("ovf.drained", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
        cyc(1'b1, 32'h200, 1'b1);
        chk("fullpp.data", data_out, 32'h100);
        chk("fullpp.valid", 32'(valid_out), 32'h1);
        chk_flags("fullpp", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("fullpp.data_out", data_out, (i == 8) ? 32'h200 : 32'h100 + 32'(i));
        end

        // Underflow, then push+pop together while empty (no fall-through).
        cyc(1'b0, 32'h0, 1'b1);
        chk("unf.valid", 32'(valid_out), 32'h0);
        chk_flags("unf", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        cyc(1'b1, 32'h300, 1'b1);
        chk("nofall.valid", 32'(valid_out), 32'h0);
        chk("nofall.occ", 32'(occupancy), 32'd1);
        chk("nofall.data_hold", data_out, 32'h200);
        cyc(1'b0, 32'h0, 1'b1);
        chk("nofall.pop", data_out, 32'h300);
        chk("nofall.unf_sticky", 32'(underflow), 32'h1);

        // Stream 20 words with a two-deep lag, wrapping both pointers.
        do_reset();
        chk("stream.unf_cleared", 32'(underflow), 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h5000 + 32'(i), (i >= 2));
            if (i >= 2) chk("stream.data", data_out, 32'h5000 + 32'(i - 2));
            if (i >= 2) chk("stream.valid", 32'(valid_out), 32'h1);
        end
        cyc(1'b0, 32'h0, 1'b1);
        chk("stream.tail0", data_out, 32'h5012);
        cyc(1'b0, 32'h0, 1'b1);
        chk("stream.tail1", data_out, 32'h5013);
        chk("stream.occ", 32'(occupancy), 32'd0);

        // Reset mid-operation, with a competing push on the reset edge.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h6000 + 32'(i), 1'b0);
        reset = 1'b1;
        cyc(1'b1, 32'hBAD, 1'b1);
        reset = 1'b0;
        chk("midrst.data", data_out, 32'h0);
        chk("midrst.valid", 32'(valid_out), 32'h0);
        chk_flags("midrst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 32'h777, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("midrst.post_word", data_out, 32'h777);
        chk("midrst.post_valid", 32'(valid_out), 32'h1);
        chk("midrst.post_occ", 32'(occupancy), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("midrst.no_stale", 32'(valid_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
